bpred_gshare_ras: RTL

// Parametrised successor to the core's BTB-only branch predictor. Predicts taken/target for the F0 PC from a

---
 rtl/bpred_gshare_ras.sv | 131 +++++++++++++
 1 files changed

// File: rtl/bpred_gshare_ras.sv
// Branch predictor for fetch stage F0: tagged direct-mapped BTB, 2-bit PHT (bimodal/gshare) and a
// return address stack, trained non-speculatively from the execute stage.
module bpred_gshare_ras #(
  parameter int BTB_ENTRIES = 64,
  parameter int PHT_ENTRIES = 256,
  parameter int GHR_BITS    = 8,
  parameter int RAS_DEPTH   = 4,
  parameter int MODE        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetchValid,
  input  logic [31:0] fetchPc,
  output logic        fetchHit,
  output logic [31:0] fetchTarget,
  input  logic        exValid,
  input  logic [31:0] exPc,
  input  logic        exBranch,
  input  logic        exIsCall,
  input  logic        exIsRet,
  input  logic        exTaken,
  input  logic [31:0] exTarget
);
  localparam int BI = $clog2(BTB_ENTRIES);
  localparam int TW = 30 - BI;
  localparam int PI = $clog2(PHT_ENTRIES);
  localparam int RP = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int RC = $clog2(RAS_DEPTH + 1);
  localparam logic [1:0] T_BR = 2'd0, T_JMP = 2'd1, T_CALL = 2'd2, T_RET = 2'd3;

  logic          btbValid  [BTB_ENTRIES];
  logic [TW-1:0] btbTag    [BTB_ENTRIES];
  logic [31:0]   btbTarget [BTB_ENTRIES];
  logic [1:0]    btbType   [BTB_ENTRIES];
  logic [1:0]    pht       [PHT_ENTRIES];
  logic [GHR_BITS-1:0] ghr;
  logic [31:0]   rasMem    [RAS_DEPTH];
  logic [RP-1:0] rasPtr;
  logic [RC-1:0] rasCount;

  function automatic logic [1:0] satCount(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'd3) ? c : c + 2'd1;
    return (c == 2'd0) ? c : c - 2'd1;
  endfunction

  function automatic logic [RP-1:0] ptrInc(input logic [RP-1:0] p);
    return (p == RP'(RAS_DEPTH - 1)) ? '0 : p + RP'(1);
  endfunction

  function automatic logic [RP-1:0] ptrDec(input logic [RP-1:0] p);
    return (p == '0) ? RP'(RAS_DEPTH - 1) : p - RP'(1);
  endfunction

  // Lookup: purely combinational, reads pre-update state
  logic [BI-1:0] fIdx;
  logic [TW-1:0] fTag;
  logic [PI-1:0] fPhtIdx;
  logic          btbHit;
  logic [1:0]    fType;
  logic [31:0]   rasTop;
  logic          unusedFetchLsb;

  assign fIdx           = fetchPc[BI+1:2];
  assign fTag           = fetchPc[31:BI+2];
  assign fType          = btbType[fIdx];
  assign rasTop         = rasMem[ptrDec(rasPtr)];
  assign btbHit         = !rst && fetchValid && btbValid[fIdx] && (btbTag[fIdx] == fTag);
  assign unusedFetchLsb = ^fetchPc[1:0];

  always_comb begin
    fPhtIdx = fetchPc[PI+1:2];
    if (MODE == 2) fPhtIdx = fPhtIdx ^ PI'(ghr);
  end

  assign fetchHit    = btbHit && ((fType != T_BR) || (MODE == 0) || pht[fPhtIdx][1]);
  assign fetchTarget = !btbHit ? 32'd0 :
                       ((fType == T_RET) && (rasCount != '0)) ? rasTop : btbTarget[fIdx];

  // Update: next-state terms from the resolved instruction
  logic [BI-1:0] exIdx;
  logic [PI-1:0] exPhtIdx;
  logic [1:0]    exType;
  logic          doPop;
  logic [RP-1:0] ptrAfterPop, rasPtrNext;
  logic [RC-1:0] cntAfterPop, rasCountNext;

  assign exIdx  = exPc[BI+1:2];
  assign exType = exIsRet ? T_RET : exIsCall ? T_CALL : exBranch ? T_BR : T_JMP;
  assign doPop  = exIsRet && (rasCount != '0);

  always_comb begin
    exPhtIdx = exPc[PI+1:2];
    if (MODE == 2) exPhtIdx = exPhtIdx ^ PI'(ghr);
    ptrAfterPop  = doPop ? ptrDec(rasPtr) : rasPtr;
    cntAfterPop  = doPop ? rasCount - RC'(1) : rasCount;
    rasPtrNext   = ptrAfterPop;
    rasCountNext = cntAfterPop;
    if (exIsCall) begin
      rasPtrNext   = ptrInc(ptrAfterPop);
      rasCountNext = (cntAfterPop == RC'(RAS_DEPTH)) ? cntAfterPop : cntAfterPop + RC'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btbValid[i] <= 1'b0;
      for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= 2'b01;
      ghr      <= '0;
      rasPtr   <= '0;
      rasCount <= '0;
    end else if (exValid) begin
      if (exBranch && (MODE != 0)) pht[exPhtIdx] <= satCount(pht[exPhtIdx], exTaken);
      if (exBranch && (MODE == 2)) ghr <= GHR_BITS'({ghr, exTaken});
      if (exTaken) btbValid[exIdx] <= 1'b1;
      rasPtr   <= rasPtrNext;
      rasCount <= rasCountNext;
    end
  end

  // Payload storage carries no reset; validity and RAS count gate its use
  always_ff @(posedge clk) begin
    if (exValid) begin
      if (exTaken) begin
        btbTag[exIdx]    <= exPc[31:BI+2];
        btbTarget[exIdx] <= exTarget;
        btbType[exIdx]   <= exType;
      end
      if (exIsCall) rasMem[ptrAfterPop] <= exPc + 32'd4;
    end
  end
endmodule
